// File: rtl/mem_ctrl_be.sv
// rtl/mem_ctrl_be.sv - single-port byte-strobed memory with init sequencer and 1/2-cycle response pipeline
module mem_ctrl_be #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DEPTH      = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic                    rsp_valid_o,
  output logic                    rsp_write_o,
  output logic                    rsp_err_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    init_done_o
);

  localparam int                    NBYTES   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_ptr_q, init_ptr_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    accept;
  logic                    in_range;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic                    s1_valid_q, s1_write_q, s1_err_q;
  logic [DATA_WIDTH-1:0]   s1_rdata_q;

  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    req_ready_o = 1'b0;
    init_done_o = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_ptr_d = init_ptr_q + ADDR_WIDTH'(1);
        if (init_ptr_q == LAST_PTR) state_d = ST_RUN;
      end
      ST_RUN: begin
        req_ready_o = 1'b1;
        init_done_o = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  assign accept   = req_valid_i & req_ready_o;
  assign in_range = {1'b0, addr_i} < DEPTH_W;
  // Read data comes from the array before this edge's update; a single port never reads and writes together.
  assign rd_word  = (in_range && !req_write_i) ? mem_q[addr_i] : '0;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (state_q == ST_INIT) begin
        mem_q[init_ptr_q] <= INIT_VALUE;
      end else if (accept && req_write_i && in_range) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (wstrb_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s1_write_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_rdata_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_write_q <= req_write_i;
        s1_err_q   <= ~in_range;
        s1_rdata_q <= rd_word;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_q, s2_write_q, s2_err_q;
      logic [DATA_WIDTH-1:0] s2_rdata_q;

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          s2_valid_q <= 1'b0;
          s2_write_q <= 1'b0;
          s2_err_q   <= 1'b0;
          s2_rdata_q <= '0;
        end else begin
          s2_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            s2_write_q <= s1_write_q;
            s2_err_q   <= s1_err_q;
            s2_rdata_q <= s1_rdata_q;
          end
        end
      end

      assign rsp_valid_o = s2_valid_q;
      assign rsp_write_o = s2_write_q;
      assign rsp_err_o   = s2_err_q;
      assign rdata_o     = s2_rdata_q;
    end else begin : g_lat1
      assign rsp_valid_o = s1_valid_q;
      assign rsp_write_o = s1_write_q;
      assign rsp_err_o   = s1_err_q;
      assign rdata_o     = s1_rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_mem_ctrl_be.sv
// tb/tb_mem_ctrl_be.sv - two DUTs (depth 16/latency 1, depth 12/latency 2) on shared stimulus vs a scheduled-response model
module tb_mem_ctrl_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             req_valid = 1'b0, req_write = 1'b0;
  logic [3:0]       addr = '0, wstrb = '0;
  logic [31:0]      wdata = '0;

  logic [1:0]       req_ready, rsp_valid, rsp_write, rsp_err, init_done;
  logic [1:0][31:0] rdata;

  mem_ctrl_be #(.ADDR_WIDTH(4), .DEPTH(16), .DATA_WIDTH(32), .RD_LATENCY(1)) u_d16_l1 (
    .clk_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[0]),
    .req_write_i(req_write), .addr_i(addr), .wdata_i(wdata), .wstrb_i(wstrb),
    .rsp_valid_o(rsp_valid[0]), .rsp_write_o(rsp_write[0]), .rsp_err_o(rsp_err[0]),
    .rdata_o(rdata[0]), .init_done_o(init_done[0]));

  mem_ctrl_be #(.ADDR_WIDTH(4), .DEPTH(12), .DATA_WIDTH(32), .RD_LATENCY(2)) u_d12_l2 (
    .clk_i(clk), .reset_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[1]),
    .req_write_i(req_write), .addr_i(addr), .wdata_i(wdata), .wstrb_i(wstrb),
    .rsp_valid_o(rsp_valid[1]), .rsp_write_o(rsp_write[1]), .rsp_err_o(rsp_err[1]),
    .rdata_o(rdata[1]), .init_done_o(init_done[1]));

  typedef struct {
    bit          v;
    bit          wr;
    bit          err;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rd0;
    bit          err1;
    logic [31:0] rd1;
  } vec_t;

  int          total = 0, bad = 0, cyc = 0;
  int          depth [2] = '{16, 12};
  int          lat   [2] = '{1, 2};
  int          clean [2] = '{0, 0};
  int          acc   [2] = '{0, 0};
  int          obs   [2] = '{0, 0};
  logic [31:0] held  [2] = '{32'h0, 32'h0};
  logic [31:0] mmem  [2][16];
  exp_t        sched [2][4];
  logic [32:0] log0[$], log1[$];
  vec_t        vt[10];

  task automatic chk(string name, int d, logic [32:0] act, logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, d, cyc, act, exp);
    end
  endtask

  task automatic model_edge(int d);
    logic        err;
    logic [31:0] data;
    if (rst) begin
      clean[d] = 0;
      held[d]  = '0;
      for (int s = 0; s < 4; s++) begin
        if (sched[d][s].v) acc[d]--;
        sched[d][s].v = 1'b0;
      end
    end else if (clean[d] < depth[d]) begin
      clean[d]++;
      if (clean[d] == depth[d])
        for (int a = 0; a < 16; a++) mmem[d][a] = 32'hFFFF_FFFF;
    end else if (req_valid) begin
      err  = (int'(addr) >= depth[d]);
      data = '0;
      if (!err && !req_write) data = mmem[d][addr];
      if (!err && req_write)
        for (int i = 0; i < 4; i++)
          if (wstrb[i]) mmem[d][addr][8*i +: 8] = wdata[8*i +: 8];
      sched[d][(cyc + lat[d] - 1) % 4] = '{1'b1, req_write, err, data};
      acc[d]++;
    end
  endtask

  task automatic check(int d);
    exp_t e;
    e = sched[d][cyc % 4];
    sched[d][cyc % 4].v = 1'b0;
    chk("req_ready", d, 33'(req_ready[d]), 33'(clean[d] >= depth[d]));
    chk("init_done", d, 33'(init_done[d]), 33'(clean[d] >= depth[d]));
    chk("rsp_valid", d, 33'(rsp_valid[d]), 33'(e.v));
    if (rsp_valid[d]) begin
      obs[d]++;
      if (d == 0) log0.push_back({rsp_err[d], rdata[d]});
      else        log1.push_back({rsp_err[d], rdata[d]});
    end
    if (e.v) begin
      held[d] = e.data;
      chk("rsp_write", d, 33'(rsp_write[d]), 33'(e.wr));
      chk("rsp_err", d, 33'(rsp_err[d]), 33'(e.err));
    end
    chk("rdata", d, 33'(rdata[d]), 33'(held[d]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) model_edge(d);
    for (int d = 0; d < 2; d++) check(d);
  endtask

  task automatic req(bit wr, logic [3:0] a, logic [31:0] wd, logic [3:0] st);
    req_valid = 1'b1;
    req_write = wr;
    addr      = a;
    wdata     = wd;
    wstrb     = st;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 40 && !(req_ready[0] && req_ready[1]); n++) tick();
    chk("ready_timeout", 0, 33'(req_ready), 33'(2'b11));
  endtask

  initial begin
    int first0, first1;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 4; s++) sched[d][s] = '{1'b0, 1'b0, 1'b0, 32'h0};

    vt[0] = '{1'b0, 4'd5,  32'h0,        4'h0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
    vt[1] = '{1'b1, 4'd3,  32'h1122_3344, 4'h5, 32'h0,         1'b0, 32'h0};
    vt[2] = '{1'b0, 4'd3,  32'h0,        4'h0, 32'hFF22_FF44, 1'b0, 32'hFF22_FF44};
    vt[3] = '{1'b1, 4'd13, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b1, 32'h0};
    vt[4] = '{1'b0, 4'd13, 32'h0,        4'h0, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vt[5] = '{1'b1, 4'd2,  32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0, 32'h0};
    vt[6] = '{1'b0, 4'd2,  32'h0,        4'h0, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5};
    vt[7] = '{1'b0, 4'd2,  32'h0,        4'h0, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5};
    vt[8] = '{1'b1, 4'd7,  32'h1234_5678, 4'h0, 32'h0,         1'b0, 32'h0};
    vt[9] = '{1'b0, 4'd7,  32'h0,        4'h0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    first0 = -1;
    first1 = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (first0 < 0 && req_ready[0]) first0 = i;
      if (first1 < 0 && req_ready[1]) first1 = i;
    end
    chk("ready_after_init", 0, 33'(first0), 33'(16));
    chk("ready_after_init", 1, 33'(first1), 33'(12));

    log0.delete();
    log1.delete();
    foreach (vt[i]) begin
      req(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].wstrb);
      tick();
    end
    req_valid = 1'b0;
    repeat (3) tick();
    chk("tbl_count", 0, 33'(log0.size()), 33'(10));
    chk("tbl_count", 1, 33'(log1.size()), 33'(10));
    foreach (vt[i]) begin
      if (i < log0.size()) chk("tbl_rsp", 0, log0[i], {1'b0, vt[i].rd0});
      if (i < log1.size()) chk("tbl_rsp", 1, log1[i], {vt[i].err1, vt[i].rd1});
    end

    for (int a = 0; a < 16; a++) begin
      req(1'b0, 4'(a), 32'h0, 4'h0);
      tick();
    end
    req_valid = 1'b0;
    repeat (3) tick();

    req(1'b1, 4'd9, 32'h1234_5678, 4'hF);
    tick();
    req(1'b0, 4'd9, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("flush_after_reset", 1, 33'(rsp_valid[1]), 33'(0));
    rst = 1'b0;
    wait_ready();
    log0.delete();
    log1.delete();
    req(1'b0, 4'd9, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    chk("reinit_count", 0, 33'(log0.size()), 33'(1));
    chk("reinit_count", 1, 33'(log1.size()), 33'(1));
    if (log0.size() > 0) chk("reinit_word", 0, log0[0], {1'b0, 32'hFFFF_FFFF});
    if (log1.size() > 0) chk("reinit_word", 1, log1[0], {1'b0, 32'hFFFF_FFFF});

    for (int i = 0; i < 3000; i++) begin
      rst       = (i == 1500);
      req_valid = ($urandom_range(0, 9) < 7);
      req_write = $urandom_range(0, 1) == 1;
      addr      = 4'($urandom_range(0, 15));
      wdata     = $urandom;
      wstrb     = 4'($urandom_range(0, 15));
      tick();
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    repeat (4) tick();
    chk("accept_vs_rsp", 0, 33'(obs[0]), 33'(acc[0]));
    chk("accept_vs_rsp", 1, 33'(obs[1]), 33'(acc[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
